// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing constants and helpers for the FIFO family
package fifo_pkg;

  localparam int DEF_B = 8;
  localparam int DEF_W = 4;

  function automatic int depth_of(input int w);
    return 1 << w;
  endfunction

  // Occupancy must reach depth itself, so it needs one bit more than a pointer.
  function automatic int level_bits(input int w);
    return $clog2((1 << w) + 1);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - B x 2**W storage, synchronous write, asynchronous read
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  localparam int DEPTH = depth_of(W);

  logic [B-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - synchronous FIFO with level, almost flags, flush and error pulses
// FIFO_RDREG_EN selects a registered read port with r_valid instead of show-ahead.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int B      = DEF_B,
  parameter int W      = DEF_W,
  parameter int AF_LVL = (1 << W) - 2,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
`ifdef FIFO_RDREG_EN
  output logic         r_valid,
`endif
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);

  localparam int DEPTH = depth_of(W);
  localparam int LW    = level_bits(W);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LVL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LVL);

  if (AF_LVL < 1 || AF_LVL > DEPTH - 1 || AE_LVL < 1 || AE_LVL > DEPTH - 1) begin : g_bad_cfg
    $error("fifo_level: AF_LVL and AE_LVL must lie in 1..2**W-1");
  end

  logic [W-1:0]  w_ptr_q, w_ptr_d;
  logic [W-1:0]  r_ptr_q, r_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          wr_acc, rd_acc;
  logic [B-1:0]  mem_rdata;

  // A flush cancels both requests outright, including their error pulses.
  assign wr_acc = wr & ~full_q & ~clr;
  assign rd_acc = rd & ~empty_q & ~clr;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    empty_d = empty_q;
    full_d  = full_q;
    ae_d    = ae_q;
    af_d    = af_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      level_d = '0;
      empty_d = 1'b1;
      full_d  = 1'b0;
      ae_d    = 1'b1;
      af_d    = 1'b0;
    end else begin
      w_ptr_d = w_ptr_q + W'(wr_acc);
      r_ptr_d = r_ptr_q + W'(rd_acc);
      level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
      empty_d = (level_d == '0);
      full_d  = (level_d == DEPTH_L);
      ae_d    = (level_d <= AE_L);
      af_d    = (level_d >= AF_L);
      ovf_d   = wr & full_q;
      unf_d   = rd & empty_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_regfile #(.B(B), .W(W)) u_regfile (
    .clk    (clk),
    .we     (wr_acc),
    .w_addr (w_ptr_q),
    .w_data (w_data),
    .r_addr (r_ptr_q),
    .r_data (mem_rdata)
  );

`ifdef FIFO_RDREG_EN
  logic [B-1:0] rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rd_acc ? mem_rdata : rdata_q;
    rvalid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign r_data  = rdata_q;
  assign r_valid = rvalid_q;
`else
  assign r_data = mem_rdata;
`endif

  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - directed bench for fifo_level (W=4, B=8, AF=14, AE=2)
module tb_fifo_level;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full;
  logic [4:0] level;
  logic       overflow, underflow;
`ifdef FIFO_RDREG_EN
  logic       r_valid;
`endif

  int passed = 0;
  int total  = 0;
  logic [7:0] q [$];

  fifo_level #(.B(8), .W(4), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (clr),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
`ifdef FIFO_RDREG_EN
    .r_valid      (r_valid),
`endif
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic head(input string tag, input logic [7:0] exp);
`ifndef FIFO_RDREG_EN
    chk(tag, 32'(r_data), 32'(exp));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; idle(); w_data = 8'h00;
    step(); step();
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; w_data = 8'hE0 + 8'(i);
      step();
    end
    chk("pre_reset_level", 32'(level), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flags", {empty, almost_empty, full, almost_full, overflow, underflow}, 6'b110000);
    idle();
    step();
    #2 reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      step();
      q.push_back(8'(i));
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
      chk("fill_full", 32'(full), 32'(i + 1 == 16));
    end
    w_data = 8'hFF;
    step();
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    idle();
    step();
    chk("ovf_clear", 32'(overflow), 32'd0);
    head("ovf_no_corrupt", 8'h00);

    for (int i = 0; i < 16; i++) begin
      head("drain_data", q.pop_front());
      rd = 1'b1;
      step();
      chk("drain_level", 32'(level), 32'(15 - i));
      chk("drain_ae", 32'(almost_empty), 32'(15 - i <= 2));
      chk("drain_empty", 32'(empty), 32'(i == 15));
    end
    step();
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_level", 32'(level), 32'd0);
    idle();
    step();
    chk("unf_clear", 32'(underflow), 32'd0);

    wr = 1'b1; rd = 1'b1; w_data = 8'hA5;
    step();
    q.push_back(8'hA5);
    chk("sim_empty_unf", 32'(underflow), 32'd1);
    chk("sim_empty_level", 32'(level), 32'd1);
    head("sim_empty_data", 8'hA5);
    idle();

    for (int i = 0; i < 15; i++) begin
      wr = 1'b1; w_data = 8'h40 + 8'(i);
      step();
      q.push_back(8'h40 + 8'(i));
    end
    chk("refill_full", 32'(full), 32'd1);
    wr = 1'b1; rd = 1'b1; w_data = 8'h77;
    step();
    void'(q.pop_front());
    chk("sim_full_ovf", 32'(overflow), 32'd1);
    chk("sim_full_unf", 32'(underflow), 32'd0);
    chk("sim_full_level", 32'(level), 32'd15);
    idle();

    for (int i = 0; i < 10; i++) begin
      head("mid_drain_data", q.pop_front());
      rd = 1'b1;
      step();
    end
    idle();
    chk("mid_level", 32'(level), 32'd5);

    for (int i = 0; i < 10; i++) begin
      head("wrap_data", q.pop_front());
      wr = 1'b1; rd = 1'b1; w_data = 8'h80 + 8'(i);
      step();
      q.push_back(8'h80 + 8'(i));
      chk("wrap_level", 32'(level), 32'd5);
    end
    idle();
    head("wrap_head", q[0]);

    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; w_data = 8'hC0 + 8'(i);
      step();
    end
    idle();
    chk("clr_pre_level", 32'(level), 32'd9);
    clr = 1'b1; wr = 1'b1; rd = 1'b1; w_data = 8'h99;
    step();
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_flags", {empty, almost_empty, full, almost_full, overflow, underflow}, 6'b110000);
    idle();
    q.delete();
    wr = 1'b1; w_data = 8'h3C;
    step();
    idle();
    chk("post_clr_level", 32'(level), 32'd1);
    head("post_clr_data", 8'h3C);

`ifdef FIFO_RDREG_EN
    clr = 1'b1;
    step();
    idle();
    wr = 1'b1; w_data = 8'h11;
    step();
    w_data = 8'h22;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    chk("rdreg_valid0", 32'(r_valid), 32'd1);
    chk("rdreg_data0", 32'(r_data), 32'h11);
    step();
    chk("rdreg_valid1", 32'(r_valid), 32'd1);
    chk("rdreg_data1", 32'(r_data), 32'h22);
    idle();
    step();
    chk("rdreg_valid_off", 32'(r_valid), 32'd0);
    chk("rdreg_hold", 32'(r_data), 32'h22);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
